// File: rtl/ble_config_loader.sv
// ble_config_loader: serialises config words onto a ble scan chain and reads the chain back in place
module ble_config_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 264,
  parameter int CNT_W     = 16
) (
  input  logic              PCLK,
  input  logic              RESETN,
  input  logic              START,
  input  logic              MODE,
  input  logic [WORD_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic [WORD_W-1:0] DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY,
  output logic              DOUT_LAST,
  output logic              SE,
  output logic              SIN,
  input  logic              CHAIN_SOUT,
  output logic              BUSY,
  output logic              DONE
);
  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [BW-1:0] WSZ = BW'(WORD_W);
  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DRAIN} state_t;
  state_t state, state_n;
  logic mode, se_r, sin_r, done_r, go, hs, last_bit;
  logic [CNT_W-1:0] cnt;
  logic [WORD_W-1:0] wreg, cap;
  logic [BW-1:0] wbits, cbits;
  logic [BW:0] fill;
  assign SE   = se_r;
  assign DONE = done_r;
  assign BUSY = state != IDLE;
  assign SIN  = (mode && BUSY) ? CHAIN_SOUT : sin_r;
  assign DOUT = DOUT_LAST ? cap << (WSZ - cbits) : cap;
  // fill counts captured bits plus the one in flight, so a registered SE never overruns cap
  always_comb begin
    DIN_READY  = state == FETCH && wbits == '0;
    DOUT_LAST  = mode && state == DRAIN && !se_r;
    DOUT_VALID = DOUT_LAST || (mode && state == SHIFT && cbits == WSZ);
    hs         = DOUT_VALID && DOUT_READY;
    fill       = {1'b0, hs ? '0 : cbits} + {{BW{1'b0}}, se_r};
    last_bit   = cnt == LEN - 1'b1;
    go         = state == SHIFT && cnt < LEN && (mode ? fill < {1'b0, WSZ} : wbits != '0);
    state_n    = state;
    case (state)
      IDLE:    state_n = START ? (MODE ? SHIFT : FETCH) : IDLE;
      FETCH:   state_n = (DIN_VALID && DIN_READY) ? SHIFT : FETCH;
      SHIFT:   state_n = !go ? SHIFT : last_bit ? DRAIN : (!mode && wbits == BW'(1)) ? FETCH : SHIFT;
      default: state_n = (!mode || hs) ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge PCLK) begin
    if (!RESETN) begin
      state  <= IDLE;
      mode   <= 1'b0;
      cnt    <= '0;
      wreg   <= '0;
      cap    <= '0;
      wbits  <= '0;
      cbits  <= '0;
      se_r   <= 1'b0;
      sin_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      done_r <= state == DRAIN && state_n == IDLE;
      se_r   <= go;
      if (state == IDLE && START) begin
        mode  <= MODE;
        cnt   <= '0;
        wbits <= '0;
        cbits <= '0;
        cap   <= '0;
      end
      if (DIN_VALID && DIN_READY) begin
        wreg  <= DIN;
        wbits <= WSZ;
      end
      if (go) cnt <= cnt + 1'b1;
      if (go && !mode) begin
        sin_r <= wreg[WORD_W-1];
        wreg  <= wreg << 1;
        wbits <= wbits - 1'b1;
      end
      if (mode && se_r) begin
        cap   <= {cap[WORD_W-2:0], CHAIN_SOUT};
        cbits <= fill[BW-1:0];
      end else if (hs) cbits <= '0;
    end
  end
endmodule
